// File: rtl/sweep_pkg.sv
// Shared types and helpers for the RF switch sweep sequencer.
// Position encoding matches the switch driver GPIO.
package sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_TRIG,
    ST_WAIT_RDY,
    ST_NEXT
  } state_t;

  localparam logic [1:0] SW_POS_0       = 2'd0;
  localparam logic [1:0] SW_POS_1       = 2'd1;
  localparam logic [1:0] SW_POS_2       = 2'd2;
  localparam logic [1:0] SW_POS_INVALID = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [1:0] pos;
  } pos_sel_t;

  // Lowest enabled position at or above 'from'; invalid when none.
  function automatic pos_sel_t next_enabled(
    input logic [2:0] mask,
    input logic [2:0] from
  );
    pos_sel_t r;
    r = '{valid: 1'b0, pos: SW_POS_INVALID};
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) begin
        r = '{valid: 1'b1, pos: 2'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/switch_sweep_sequencer_if.sv
// Command/status bundle between the UART decoder and the sweep sequencer.
// master = command decoder, slave = sequencer.
interface switch_sweep_sequencer_if;

  logic       start;
  logic       abort;
  logic       continuous;
  logic [2:0] pos_mask;
  logic       manual_load;
  logic [1:0] manual_pos;
  logic       busy;
  logic       done;
  logic       timeout_err;

  modport master (
    output start,
    output abort,
    output continuous,
    output pos_mask,
    output manual_load,
    output manual_pos,
    input  busy,
    input  done,
    input  timeout_err
  );

  modport slave (
    input  start,
    input  abort,
    input  continuous,
    input  pos_mask,
    input  manual_load,
    input  manual_pos,
    output busy,
    output done,
    output timeout_err
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser with a registered rising-edge pulse.
// A pin edge shows up on 'rise' three clocks after it is first sampled.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta   <= d;
      sync   <= meta;
      sync_d <= sync;
      rise   <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/switch_sweep_sequencer.sv
// Steps the VNA RF switch through enabled positions, one triggered
// acquisition per position, with settle, trigger and ACQ-RDY timeout.
module switch_sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2500000,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter int CNT_W          = 28
) (
  input  logic                     clk_50,
  input  logic                     rst,
  switch_sweep_sequencer_if.slave  bus,
  input  logic                     acq_rdy,
  output logic [1:0]               switch_state,
  output logic                     vna_trig
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRIG_LD   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sw_q, sw_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;

  logic     rdy_rise;
  pos_sel_t first_sel;
  pos_sel_t lowest_sel;
  pos_sel_t higher_sel;

  sync_edge_detect u_rdy_sync (
    .clk  (clk_50),
    .rst  (rst),
    .d    (acq_rdy),
    .rise (rdy_rise)
  );

  assign first_sel  = next_enabled(bus.pos_mask, 3'd0);
  assign lowest_sel = next_enabled(mask_q, 3'd0);
  assign higher_sel = next_enabled(mask_q, {1'b0, sw_q} + 3'd1);

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      sw_q    <= SW_POS_0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    sw_d    = sw_q;
    trig_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tmo_d   = tmo_q;
    cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

    if (bus.abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && first_sel.valid) begin
            mask_d  = bus.pos_mask;
            sw_d    = first_sel.pos;
            tmo_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LD;
          end else if (bus.manual_load &&
                       bus.manual_pos != SW_POS_INVALID) begin
            sw_d = bus.manual_pos;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = ST_TRIG;
            trig_d  = 1'b1;
            cnt_d   = TRIG_LD;
          end
        end
        ST_TRIG: begin
          if (cnt_q == '0) begin
            state_d = ST_WAIT_RDY;
            cnt_d   = TMO_LD;
          end else begin
            trig_d = 1'b1;
          end
        end
        ST_WAIT_RDY: begin
          // a late edge on the final count still advances
          if (rdy_rise) begin
            state_d = ST_NEXT;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            tmo_d   = 1'b1;
          end
        end
        ST_NEXT: begin
          if (higher_sel.valid) begin
            sw_d    = higher_sel.pos;
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LD;
          end else if (bus.continuous && lowest_sel.valid) begin
            sw_d    = lowest_sel.pos;
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LD;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign switch_state    = sw_q;
  assign vna_trig        = trig_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_switch_sweep_sequencer.sv
// Bench for switch_sweep_sequencer: directed and randomised sweeps
// checked every cycle against a timeline built from the sweep rules.
module tb_switch_sweep_sequencer;

  localparam int S   = 4;
  localparam int T   = 2;
  localparam int TO  = 20;
  // pin rise -> edge seen (+3) -> NEXT (+1) -> new switch position (+1)
  localparam int LAT = 5;
  localparam int N   = 1024;

  logic       clk_50 = 1'b0;
  logic       rst    = 1'b1;
  logic       acq_rdy = 1'b0;
  logic [1:0] switch_state;
  logic       vna_trig;

  switch_sweep_sequencer_if bus ();

  switch_sweep_sequencer #(
    .SETTLE_CYCLES  (S),
    .TRIG_CYCLES    (T),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (28)
  ) dut (
    .clk_50       (clk_50),
    .rst          (rst),
    .bus          (bus.slave),
    .acq_rdy      (acq_rdy),
    .switch_state (switch_state),
    .vna_trig     (vna_trig)
  );

  always #10 clk_50 = ~clk_50;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] e_sw  [N];
  bit         e_trg [N];
  bit         e_bsy [N];
  bit         e_dn  [N];
  bit         e_tmo [N];
  bit         d_pin [N];
  bit         d_cnt [N];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] sw,
                         input bit trg, input bit bsy, input bit dn,
                         input bit tmo);
    chk({tag, ".sw"},   32'(switch_state), 32'(sw));
    chk({tag, ".trig"}, 32'(vna_trig), 32'(trg));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
    chk({tag, ".done"}, 32'(bus.done), 32'(dn));
    chk({tag, ".tmo"},  32'(bus.timeout_err), 32'(tmo));
  endtask

  // Build the expected timeline, then drive and check cycle by cycle.
  // Cycle 0 is the first cycle after the edge that samples start.
  task automatic run_sweep(input string tag, input logic [2:0] mask,
                           input int passes, input int to_step,
                           input int abort_cyc, input int dfix,
                           input bit hi);
    int pq[$];
    int c, w, x, d, g, h, endc;
    bit timed_out;
    for (int p = 0; p < passes; p++)
      for (int b = 0; b < 3; b++)
        if (mask[b]) pq.push_back(b);
    for (int i = 0; i < N; i++) begin
      e_sw[i] = 2'd0; e_trg[i] = 0; e_bsy[i] = 0;
      e_dn[i] = 0; e_tmo[i] = 0; d_pin[i] = hi; d_cnt[i] = 0;
    end
    c = 0;
    endc = 0;
    timed_out = 0;
    for (int k = 0; k < pq.size() && !timed_out; k++) begin
      w = c + S + T;
      for (int i = c + S; i < w; i++) e_trg[i] = 1;
      if (k == to_step) begin
        endc = w + TO;
        timed_out = 1;
        for (int i = c; i < endc; i++) e_sw[i] = 2'(pq[k]);
      end else begin
        d = (dfix >= 0) ? dfix : int'($urandom_range(0, 3));
        if (hi) begin
          g = int'($urandom_range(1, 2));
          x = w + d + g;
          for (int i = x - g; i < x; i++) d_pin[i] = 0;
        end else begin
          h = int'($urandom_range(1, 3));
          x = w + d;
          for (int i = x; i < x + h; i++) d_pin[i] = 1;
        end
        for (int i = c; i < x + LAT; i++) begin
          e_sw[i]  = 2'(pq[k]);
          d_cnt[i] = (passes > 1) && (k < pq.size() - 1);
        end
        c = x + LAT;
      end
    end
    if (!timed_out) begin
      endc = c;
      e_dn[endc] = 1;
    end
    for (int i = 0; i < endc; i++) e_bsy[i] = 1;
    for (int i = endc; i < N; i++) begin
      e_sw[i]  = e_sw[endc-1];
      e_tmo[i] = timed_out;
    end
    if (abort_cyc >= 0 && abort_cyc < endc) begin
      for (int i = abort_cyc + 1; i < N; i++) begin
        e_sw[i] = e_sw[abort_cyc];
        e_trg[i] = 0; e_bsy[i] = 0; e_dn[i] = 0; e_tmo[i] = 0;
      end
      endc = abort_cyc + 1;
    end

    bus.pos_mask   = mask;
    bus.continuous = (passes > 1);
    bus.start      = 1'b1;
    tick();
    for (int n = 0; n < endc + 4; n++) begin
      acq_rdy         = d_pin[n];
      bus.continuous  = d_cnt[n];
      bus.abort       = (n == abort_cyc);
      bus.pos_mask    = 3'($urandom);
      bus.start       = 1'b0;
      bus.manual_load = 1'b0;
      if (e_bsy[n] && $urandom_range(0, 7) == 0) begin
        bus.manual_load = 1'b1;
        bus.manual_pos  = 2'($urandom);
      end
      if (e_bsy[n] && $urandom_range(0, 7) == 0) bus.start = 1'b1;
      @(negedge clk_50);
      chk_all($sformatf("%s@%0d", tag, n), e_sw[n], e_trg[n],
              e_bsy[n], e_dn[n], e_tmo[n]);
      tick();
    end
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.manual_load = 1'b0;
    bus.continuous  = 1'b0;
  endtask

  task automatic settle_pin(input bit lvl);
    acq_rdy = lvl;
    repeat (5) tick();
  endtask

  initial begin
    int total, to, ab;
    bit hi;
    logic [2:0] m;
    int p;

    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.continuous  = 1'b0;
    bus.pos_mask    = 3'b000;
    bus.manual_load = 1'b0;
    bus.manual_pos  = 2'd0;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk_50);
    chk_all("reset", 2'd0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    bus.manual_pos = 2'd2; bus.manual_load = 1'b1;
    tick();
    bus.manual_load = 1'b0;
    @(negedge clk_50);
    chk("man_pos2", 32'(switch_state), 32'd2);
    bus.manual_pos = 2'd3; bus.manual_load = 1'b1;
    tick();
    bus.manual_load = 1'b0;
    @(negedge clk_50);
    chk("man_pos3_ignored", 32'(switch_state), 32'd2);
    bus.manual_pos = 2'd1; bus.manual_load = 1'b1;
    tick();
    bus.manual_load = 1'b0;
    @(negedge clk_50);
    chk("man_pos1", 32'(switch_state), 32'd1);

    bus.pos_mask = 3'b000; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    @(negedge clk_50);
    chk_all("start_mask0", 2'd1, 0, 0, 0, 0);
    tick();
    @(negedge clk_50);
    chk_all("start_mask0_b", 2'd1, 0, 0, 0, 0);

    bus.pos_mask = 3'b111; bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk_50);
    chk_all("abort_beats_start", 2'd1, 0, 0, 0, 0);
    tick();

    settle_pin(0);
    run_sweep("dir101", 3'b101, 1, -1, -1, 2, 0);
    settle_pin(0);
    run_sweep("cont011", 3'b011, 2, -1, -1, 2, 0);
    settle_pin(0);
    run_sweep("tmo", 3'b110, 1, 0, -1, 2, 0);
    settle_pin(0);
    @(negedge clk_50);
    chk("tmo_sticky", 32'(bus.timeout_err), 32'd1);
    tick();
    settle_pin(1);
    run_sweep("held_hi", 3'b011, 1, -1, -1, -1, 1);
    settle_pin(0);
    run_sweep("abort_trig", 3'b111, 1, -1, S, -1, 0);
    settle_pin(0);
    run_sweep("edge_at_tmo", 3'b100, 1, -1, -1, TO - 4, 0);

    for (int r = 0; r < 14; r++) begin
      m = 3'($urandom_range(1, 7));
      p = int'($urandom_range(1, 3));
      total = $countones(m) * p;
      to = ($urandom_range(0, 3) == 0) ?
           int'($urandom_range(0, total - 1)) : -1;
      ab = ($urandom_range(0, 3) == 0) ?
           int'($urandom_range(0, 60)) : -1;
      hi = 1'($urandom_range(0, 1));
      settle_pin(hi);
      run_sweep($sformatf("rnd%0d", r), m, p, to, ab, -1, hi);
    end

    settle_pin(0);
    bus.pos_mask = 3'b010; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (S) tick();
    @(negedge clk_50);
    chk("rst_mid.trig_pre", 32'(vna_trig), 32'd1);
    chk("rst_mid.sw_pre", 32'(switch_state), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk_50);
    chk_all("rst_mid", 2'd0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_sweep_sequencer.md
Name: switch_sweep_sequencer

Overview:
Sequences the VNA RF switch through its enabled positions (0, 1, 2) and triggers one VNA acquisition per position. For each position it settles the switch, pulses VNA-TRIG, and waits for ACQ-RDY before moving on. It sits between the UART command decoder and the switch/trigger GPIO. It also owns switch_state, which feeds LED_STATUS and the switch drivers.

Parameters:
SETTLE_CYCLES, 2500000, clk_50 cycles to hold after a switch change before triggering (50 ms).
TRIG_CYCLES, 500, width of the vna_trig pulse in clk_50 cycles (10 us).
TIMEOUT_CYCLES, 250000000, maximum cycles spent waiting for acq_rdy (5 s).
CNT_W, 28, width of the shared down-counter; must hold the largest of the three parameters.

Ports:
clk_50  in  1  main global clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins a sweep when idle
abort  in  1  level; forces a return to IDLE
continuous  in  1  sampled at NEXT; 1 = wrap back to the first enabled position
pos_mask  in  3  enabled switch positions; latched at start
manual_load  in  1  single-cycle pulse; loads manual_pos when idle
manual_pos  in  2  requested switch position (3 is invalid)
acq_rdy  in  1  VNA ACQ-RDY, asynchronous
switch_state  out  2  current switch position
vna_trig  out  1  VNA trigger pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at the end of a non-continuous sweep
timeout_err  out  1  sticky; set on acq_rdy timeout

Behaviour:
- Reset values: switch_state=0, vna_trig=0, busy=0, done=0, timeout_err=0; FSM=IDLE; latched mask=0; counter=0.
- All outputs are registered.
- FSM states: IDLE, SETTLE, TRIG, WAIT_RDY, NEXT.
- IDLE:
  - start with pos_mask!=0: latch the mask; load the lowest enabled position into switch_state; clear timeout_err; go to SETTLE. switch_state and busy change on the cycle after start.
  - start with pos_mask==0: ignored; no done, no state change.
  - manual_load with manual_pos<=2: switch_state=manual_pos next cycle. manual_pos==3 is ignored.
  - manual_load in any state other than IDLE is ignored.
- SETTLE: hold for exactly SETTLE_CYCLES cycles, then go to TRIG.
- TRIG: vna_trig is high for exactly TRIG_CYCLES consecutive cycles, then go to WAIT_RDY.
- WAIT_RDY:
  - Advance on a rising edge of the synchronised acq_rdy.
  - If acq_rdy is already high on entry, it must go low and then high again before the block advances.
  - If TIMEOUT_CYCLES elapse from entry with no edge: set timeout_err, drop busy, go to IDLE. switch_state is held; done is not pulsed.
  - An edge and a timeout on the same cycle: the edge wins.
- NEXT (one cycle):
  - A higher enabled position exists: load it into switch_state and go to SETTLE.
  - Otherwise, continuous=1: load the lowest enabled position and go to SETTLE.
  - Otherwise: pulse done for one cycle and go to IDLE. busy falls on the same cycle that done is high.
- acq_rdy sync: 2-flop synchroniser plus edge register. An input edge is seen 3 cycles after it arrives at the pin.
- abort is high in any state: next cycle FSM=IDLE, vna_trig=0, busy=0, no done. switch_state is held.
- Priority:
  - abort beats start, and abort beats the acq_rdy edge.
  - start received while busy is ignored.
- Counter: a single CNT_W down-counter, reloaded on every state entry. It never wraps; it saturates at 0.
- rst mid-sweep: every register returns to its reset value on the next edge, including vna_trig (low).

Decomposition:
- Shared package sweep_pkg:
  - FSM state encoding constants.
  - SW_POS_0/1/2 constants and SW_POS_INVALID=3.
  - A function returning the next enabled position above a given index, or an invalid flag.
- One sub-module, sync_edge_detect: 2-flop synchroniser with a registered rising-edge pulse. It is reused later for GPIO_2_7.

Test Plan:
All scenarios run with SETTLE=4, TRIG=2, TIMEOUT=20.
- start, pos_mask=3'b101, continuous=0; pin acq_rdy rises 2 cycles after each trig falls -> switch_state goes 0 then 2; two vna_trig pulses of 2 cycles each; each pulse starts 4 cycles after the switch change; one done pulse; busy falls with done.
- continuous=1, mask=3'b011 -> switch_state sequence is 0,1,0,1…; deassert continuous during the second pass -> done after position 1.
- acq_rdy held low -> timeout_err=1 exactly 20 cycles after WAIT_RDY entry; busy=0; done never asserted; the next start clears timeout_err.
- acq_rdy held high throughout -> no advance until it goes low then high; advance occurs 3 cycles after the re-rise.
- abort during TRIG (vna_trig=1) -> vna_trig=0 and busy=0 on the next cycle; switch_state is unchanged.
- manual_load pos=2 in IDLE -> switch_state=2; pos=3 -> no change; manual_load while busy -> ignored. start with mask=0 -> busy stays 0.
